// File: rtl/ksk_mgr_cut_dispatch.sv
// rtl/ksk_mgr_cut_dispatch.sv - routes KSK beats round-robin over cuts into double-buffered cut RAM slots
module ksk_mgr_cut_dispatch #(
    parameter int KSK_CUT_NB = 16,
    parameter int DATA_W     = 64,
    parameter int CUT_DEPTH  = 32,
    parameter int SLOT_NB    = 2,
    localparam int CUT_W  = $clog2(KSK_CUT_NB + 1),
    localparam int IDX_W  = (KSK_CUT_NB > 1) ? $clog2(KSK_CUT_NB) : 1,
    localparam int ADD_W  = $clog2(CUT_DEPTH),
    localparam int SLOT_W = (SLOT_NB > 1) ? $clog2(SLOT_NB) : 1
) (
    input  logic              clk,
    input  logic              s_rst_n,
    input  logic [CUT_W-1:0]  cfg_cut_nb,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_cut,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [ADD_W-1:0]  wr_add,
    output logic [DATA_W-1:0] wr_data,
    output logic              slot_done,
    output logic [SLOT_W-1:0] slot_done_id,
    input  logic              slot_free,
    input  logic [SLOT_W-1:0] slot_free_id,
    output logic              error
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [CUT_W-1:0]  MAX_NB    = CUT_W'(KSK_CUT_NB);
    localparam logic [ADD_W-1:0]  LAST_ADD  = ADD_W'(CUT_DEPTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_NB - 1);

    logic [0:0]        state;
    logic [SLOT_W-1:0] ptr;
    logic [SLOT_NB-1:0] full;
    logic [SLOT_NB-1:0] full_nxt;
    logic [IDX_W-1:0]  cut_cnt;
    logic [ADD_W-1:0]  add_cnt;
    logic [CUT_W-1:0]  cut_nb_r;

    logic              hs;
    logic              first_beat;
    logic              cfg_bad;
    logic              last_cut;
    logic              last_beat;
    logic              free_ok;
    logic              free_bad;
    logic [CUT_W-1:0]  eff_nb;
    logic [IDX_W-1:0]  last_idx;

    assign in_rdy     = (state == S_FILL);
    assign hs         = in_rdy & in_vld;
    assign first_beat = (cut_cnt == '0) && (add_cnt == '0);
    assign cfg_bad    = (cfg_cut_nb == '0) || (cfg_cut_nb > MAX_NB);

    // The first beat of a slot uses the live config; later beats use the latched copy.
    assign eff_nb    = !first_beat ? cut_nb_r : (cfg_bad ? MAX_NB : cfg_cut_nb);
    assign last_idx  = IDX_W'(eff_nb - CUT_W'(1));
    assign last_cut  = (cut_cnt == last_idx);
    assign last_beat = last_cut && (add_cnt == LAST_ADD);

    assign free_ok  = slot_free && full[slot_free_id];
    assign free_bad = slot_free && !full[slot_free_id];

    // The slot being filled is never full, so a legal free cannot collide with the done flag.
    always_comb begin
        full_nxt = full;
        if (free_ok) begin
            full_nxt[slot_free_id] = 1'b0;
        end
        if (hs && last_beat) begin
            full_nxt[ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            full         <= '0;
            cut_cnt      <= '0;
            add_cnt      <= '0;
            cut_nb_r     <= '0;
            wr_en        <= 1'b0;
            wr_cut       <= '0;
            wr_slot      <= '0;
            wr_add       <= '0;
            wr_data      <= '0;
            slot_done    <= 1'b0;
            slot_done_id <= '0;
            error        <= 1'b0;
        end else begin
            full      <= full_nxt;
            wr_en     <= hs;
            slot_done <= hs && last_beat;
            if (hs) begin
                wr_cut  <= cut_cnt;
                wr_add  <= add_cnt;
                wr_slot <= ptr;
                wr_data <= in_data;
            end
            if (hs && last_beat) begin
                slot_done_id <= ptr;
            end
            if ((hs && first_beat && cfg_bad) || free_bad) begin
                error <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (!full[ptr]) begin
                        state <= S_FILL;
                    end
                end
                default: begin
                    if (hs) begin
                        if (first_beat) begin
                            cut_nb_r <= eff_nb;
                        end
                        if (last_beat) begin
                            cut_cnt <= '0;
                            add_cnt <= '0;
                            ptr     <= (ptr == LAST_SLOT) ? '0 : ptr + SLOT_W'(1);
                            state   <= S_IDLE;
                        end else if (last_cut) begin
                            cut_cnt <= '0;
                            add_cnt <= add_cnt + ADD_W'(1);
                        end else begin
                            cut_cnt <= cut_cnt + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksk_mgr_cut_dispatch.sv
// tb/tb_ksk_mgr_cut_dispatch.sv - self-checking bench for ksk_mgr_cut_dispatch
module tb_ksk_mgr_cut_dispatch;

    localparam int KSK_CUT_NB = 16;
    localparam int DATA_W     = 64;
    localparam int CUT_DEPTH  = 32;
    localparam int SLOT_NB    = 2;
    localparam int CUT_W      = 5;
    localparam int IDX_W      = 4;
    localparam int ADD_W      = 5;
    localparam int SLOT_W     = 1;

    logic              clk = 1'b0;
    logic              s_rst_n;
    logic [CUT_W-1:0]  cfg_cut_nb;
    logic [DATA_W-1:0] in_data;
    logic              in_vld;
    logic              in_rdy;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_cut;
    logic [SLOT_W-1:0] wr_slot;
    logic [ADD_W-1:0]  wr_add;
    logic [DATA_W-1:0] wr_data;
    logic              slot_done;
    logic [SLOT_W-1:0] slot_done_id;
    logic              slot_free;
    logic [SLOT_W-1:0] slot_free_id;
    logic              error;

    always #5 clk = ~clk;

    ksk_mgr_cut_dispatch #(
        .KSK_CUT_NB(KSK_CUT_NB),
        .DATA_W    (DATA_W),
        .CUT_DEPTH (CUT_DEPTH),
        .SLOT_NB   (SLOT_NB)
    ) dut (
        .clk         (clk),
        .s_rst_n     (s_rst_n),
        .cfg_cut_nb  (cfg_cut_nb),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .wr_en       (wr_en),
        .wr_cut      (wr_cut),
        .wr_slot     (wr_slot),
        .wr_add      (wr_add),
        .wr_data     (wr_data),
        .slot_done   (slot_done),
        .slot_done_id(slot_done_id),
        .slot_free   (slot_free),
        .slot_free_id(slot_free_id),
        .error       (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beat k of a slot lands at cut k%nb, address k/nb.
    int          m_k, m_nb, m_ptr;
    bit [1:0]    m_full;
    bit          m_err;
    bit          mon_on = 1'b0;
    bit          e_wr_en, e_done;
    int          e_cut, e_add, e_slot, e_done_id;
    logic [63:0] e_data;

    always @(negedge clk) begin : monitor
        bit mhs;
        bit mfree_ok;
        if (mon_on) begin
            check("wr_en", wr_en, e_wr_en);
            if (e_wr_en) begin
                check("wr_cut", wr_cut, e_cut);
                check("wr_add", wr_add, e_add);
                check("wr_slot", wr_slot, e_slot);
                check("wr_data", wr_data, e_data);
            end
            check("slot_done", slot_done, e_done);
            if (e_done) check("slot_done_id", slot_done_id, e_done_id);
            check("error", error, m_err);
            if (m_full[m_ptr]) check("in_rdy_on_full_slot", in_rdy, 0);
        end
        if (!s_rst_n) begin
            m_k = 0; m_nb = KSK_CUT_NB; m_ptr = 0; m_full = '0; m_err = 0;
            e_wr_en = 0; e_done = 0;
            mon_on = 1'b1;
        end else begin
            mhs      = in_vld && in_rdy;
            mfree_ok = slot_free && m_full[slot_free_id];
            if (slot_free && !m_full[slot_free_id]) m_err = 1;
            e_wr_en = mhs;
            e_done  = 0;
            if (mhs) begin
                if (m_k == 0) begin
                    if (cfg_cut_nb == 0 || int'(cfg_cut_nb) > KSK_CUT_NB) begin
                        m_nb  = KSK_CUT_NB;
                        m_err = 1;
                    end else begin
                        m_nb = int'(cfg_cut_nb);
                    end
                end
                e_cut  = m_k % m_nb;
                e_add  = m_k / m_nb;
                e_slot = m_ptr;
                e_data = in_data;
                if (m_k == m_nb * CUT_DEPTH - 1) begin
                    e_done         = 1;
                    e_done_id      = m_ptr;
                    m_full[m_ptr]  = 1;
                    m_ptr          = (m_ptr + 1) % SLOT_NB;
                    m_k            = 0;
                end else begin
                    m_k++;
                end
            end
            if (mfree_ok) m_full[slot_free_id] = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst_n = 1'b0; in_vld = 1'b0; slot_free = 1'b0;
        tick(); tick();
        s_rst_n = 1'b1;
    endtask

    task automatic free_slot(input int id);
        slot_free = 1'b1; slot_free_id = SLOT_W'(id);
        tick();
        slot_free = 1'b0;
    endtask

    // Streams one slot; cfg is scrambled after the first beat to prove it is latched.
    task automatic fill_slot(input int cfg, input int pct, input int free_id, input int exp_beats,
                             output int beats, output int done_id);
        int cyc;
        bit hs;
        bit fin;
        beats = 0; cyc = 0; fin = 0; done_id = -1;
        cfg_cut_nb = CUT_W'(cfg);
        while (!fin && cyc < 4000) begin
            in_vld  = (int'($urandom_range(0, 99)) < pct) || (free_id >= 0 && beats == exp_beats - 1);
            in_data = {$urandom, $urandom};
            if (free_id >= 0 && beats == exp_beats - 1) begin
                slot_free = 1'b1; slot_free_id = SLOT_W'(free_id);
            end
            @(negedge clk);
            hs = in_vld && in_rdy;
            tick();
            cyc++;
            slot_free = 1'b0;
            if (hs) begin
                beats++;
                if (beats == 1) cfg_cut_nb = CUT_W'($urandom_range(0, 31));
            end
            if (slot_done) begin
                fin = 1;
                done_id = int'(slot_done_id);
            end
        end
        in_vld = 1'b0;
        check("fill_finished", fin, 1);
    endtask

    typedef struct {
        bit rst;
        int cfg;
        int pct;
        int exp_beats;
        bit exp_err;
        int exp_id;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, id, cnt, cyc, cfg, exp_b;
        vecs[0] = '{0, 16, 100, 512, 0, 0};
        vecs[1] = '{0,  4,  70, 128, 0, 1};
        vecs[2] = '{0,  8,  50, 256, 0, 0};
        vecs[3] = '{0,  1, 100,  32, 0, 1};
        vecs[4] = '{0,  5,  80, 160, 0, 0};
        vecs[5] = '{1,  0,  90, 512, 1, 0};
        vecs[6] = '{1, 17,  90, 512, 1, 0};
        vecs[7] = '{1, 31,  90, 512, 1, 0};
        vecs[8] = '{0,  3,  60,  96, 1, 1};

        s_rst_n = 1'b0; in_vld = 1'b0; in_data = '0; cfg_cut_nb = CUT_W'(16);
        slot_free = 1'b0; slot_free_id = '0;
        tick(); tick();
        check("rst_in_rdy", in_rdy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_cut", wr_cut, 0);
        check("rst_wr_slot", wr_slot, 0);
        check("rst_wr_add", wr_add, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_slot_done", slot_done, 0);
        check("rst_slot_done_id", slot_done_id, 0);
        check("rst_error", error, 0);
        s_rst_n = 1'b1;
        tick();
        check("post_rst_in_rdy", in_rdy, 1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            fill_slot(vecs[i].cfg, vecs[i].pct, -1, vecs[i].exp_beats, beats, id);
            check($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
            check($sformatf("vec%0d_done_id", i), id, vecs[i].exp_id);
            check($sformatf("vec%0d_error", i), error, vecs[i].exp_err);
            free_slot(id);
        end

        // Both slots full: input stalls until slot 0 is released.
        do_reset();
        fill_slot(1, 100, -1, 32, beats, id);
        fill_slot(1, 100, -1, 32, beats, id);
        cfg_cut_nb = CUT_W'(1);
        in_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("blocked_in_rdy", in_rdy, 0);
        end
        slot_free = 1'b1; slot_free_id = 1'b0;
        tick();
        slot_free = 1'b0;
        check("free_plus1_in_rdy", in_rdy, 0);
        tick();
        check("free_plus2_in_rdy", in_rdy, 1);
        tick();
        check("resume_wr_en", wr_en, 1);
        check("resume_wr_slot", wr_slot, 0);
        check("resume_wr_cut", wr_cut, 0);
        check("resume_wr_add", wr_add, 0);
        for (int i = 0; i < 31; i++) tick();
        in_vld = 1'b0;
        check("resume_slot_done", slot_done, 1);

        // Done of slot 1 coincides with free of slot 0.
        free_slot(1);
        fill_slot(1, 100, 0, 32, beats, id);
        check("coinc_done_id", id, 1);
        check("coinc_idle_in_rdy", in_rdy, 0);
        tick();
        check("coinc_nostall_in_rdy", in_rdy, 1);
        cfg_cut_nb = CUT_W'(1);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("coinc_wr_en", wr_en, 1);
        check("coinc_wr_slot", wr_slot, 0);

        // Free of the slot being filled is illegal.
        do_reset();
        tick();
        free_slot(0);
        check("bad_free_error", error, 1);
        fill_slot(4, 100, -1, 128, beats, id);
        check("bad_free_beats", beats, 128);
        check("bad_free_error_sticky", error, 1);

        // Reset in the middle of a slot with 50% gaps.
        do_reset();
        cfg_cut_nb = CUT_W'(16);
        cnt = 0; cyc = 0;
        while (cnt < 100 && cyc < 2000) begin
            bit hs;
            in_vld  = ($urandom_range(0, 1) == 1);
            in_data = {$urandom, $urandom};
            @(negedge clk);
            hs = in_vld && in_rdy;
            tick();
            cyc++;
            if (hs) cnt++;
        end
        check("midrst_beats", cnt, 100);
        s_rst_n = 1'b0;
        in_vld = 1'b1;
        tick();
        check("midrst_wr_en", wr_en, 0);
        check("midrst_slot_done", slot_done, 0);
        check("midrst_in_rdy", in_rdy, 0);
        in_vld = 1'b0;
        s_rst_n = 1'b1;
        fill_slot(16, 50, -1, 512, beats, id);
        check("midrst_restart_beats", beats, 512);
        check("midrst_restart_id", id, 0);
        free_slot(id);

        // Random slots, occasionally with illegal counts.
        for (int i = 0; i < 12; i++) begin
            cfg   = int'($urandom_range(0, 18));
            exp_b = ((cfg == 0 || cfg > KSK_CUT_NB) ? KSK_CUT_NB : cfg) * CUT_DEPTH;
            fill_slot(cfg, int'($urandom_range(30, 100)), -1, exp_b, beats, id);
            check($sformatf("rand%0d_beats", i), beats, exp_b);
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            free_slot(id);
        end

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
